// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder built around one full-adder cell and a
//   registered carry. Operands and carry-in are captured on an accepted start,
//   one bit is processed per clock (LSB first), and after WIDTH cycles the full
//   sum and carry-out are presented together with a one-cycle done pulse.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  begin an addition; sampled only while busy is low
//   a, b   WIDTH-bit operands, captured on the accepted start edge
//   ci     carry-in, captured on the accepted start edge
//   busy   high while an operation is in flight (RUN and DONE)
//   done   one-cycle pulse, s/co valid
//   s      registered sum, held until the next completion
//   co     registered carry-out, held until the next completion
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic cin);
        return {(x & y) | (y & cin) | (cin & x), x ^ y ^ cin};
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic             load_s;
    logic             step_s;
    logic             finish_s;

    logic [WIDTH-1:0] ra_r;
    logic [WIDTH-1:0] rb_r;
    logic [WIDTH-1:0] psum_r;
    logic [WIDTH-1:0] psum_nxt_s;
    logic             carry_r;
    logic [CNT_W-1:0] count_r;
    logic [1:0]       fa_s;

    logic [WIDTH-1:0] s_r;
    logic             co_r;
    logic             busy_r;
    logic             done_r;

    assign fa_s = full_add(ra_r[0], rb_r[0], carry_r);

    // The new sum bit enters at the MSB while older bits move toward the LSB,
    // so after WIDTH steps bit 0 of the sum lands in bit 0. Written as a
    // shift/or so it also holds for WIDTH == 1.
    assign psum_nxt_s = (WIDTH'(fa_s[0]) << (WIDTH - 1)) | (psum_r >> 1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (count_r == CNT_LAST) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, carry, bit counter and partial sum
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_r    <= '0;
            rb_r    <= '0;
            psum_r  <= '0;
            carry_r <= 1'b0;
            count_r <= '0;
        end else if (load_s) begin
            ra_r    <= a;
            rb_r    <= b;
            psum_r  <= '0;
            carry_r <= ci;
            count_r <= '0;
        end else if (step_s) begin
            ra_r    <= ra_r >> 1;
            rb_r    <= rb_r >> 1;
            psum_r  <= psum_nxt_s;
            carry_r <= fa_s[1];
            count_r <= count_r + CNT_W'(1);
        end else begin
            ra_r    <= ra_r;
            rb_r    <= rb_r;
            psum_r  <= psum_r;
            carry_r <= carry_r;
            count_r <= count_r;
        end
    end

    // Result registers: updated only on the completion edge
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r  <= '0;
            co_r <= 1'b0;
        end else if (finish_s) begin
            s_r  <= psum_nxt_s;
            co_r <= fa_s[1];
        end else begin
            s_r  <= s_r;
            co_r <= co_r;
        end
    end

    // Status flags registered from the next state so they track state_r exactly
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign s    = s_r;
    assign co   = co_r;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder at WIDTH = 8, 1 and 13, plus a sweep of
//   operand vectors per width checked against a + b + ci.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic        clk;
    logic        rst;

    logic        start8, ci8, busy8, done8, co8;
    logic [7:0]  a8, b8, s8;
    logic        start1, ci1, busy1, done1, co1;
    logic [0:0]  a1, b1, s1;
    logic        start13, ci13, busy13, done13, co13;
    logic [12:0] a13, b13, s13;

    int checks;
    int errors;
    int cyc;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .busy(busy1), .done(done1), .s(s1), .co(co1)
    );

    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .ci(ci13),
        .busy(busy13), .done(done13), .s(s13), .co(co13)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_done(input int sel);
        case (sel)
            0:       return done8;
            1:       return done1;
            default: return done13;
        endcase
    endfunction

    function automatic logic cur_busy(input int sel);
        case (sel)
            0:       return busy8;
            1:       return busy1;
            default: return busy13;
        endcase
    endfunction

    function automatic logic [31:0] cur_res(input int sel);
        case (sel)
            0:       return 32'({co8, s8});
            1:       return 32'({co1, s1});
            default: return 32'({co13, s13});
        endcase
    endfunction

    // Present operands with start for one edge, then scramble the inputs.
    task automatic launch(input int sel, input logic [12:0] av, input logic [12:0] bv, input logic civ);
        case (sel)
            0: begin start8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; ci8 = civ; end
            1: begin start1 = 1'b1; a1 = av[0:0]; b1 = bv[0:0]; ci1 = civ; end
            default: begin start13 = 1'b1; a13 = av; b13 = bv; ci13 = civ; end
        endcase
        tick();
        start8 = 1'b0; start1 = 1'b0; start13 = 1'b0;
        a8 = ~av[7:0]; b8 = ~bv[7:0]; ci8 = ~civ;
        a1 = ~av[0:0]; b1 = ~bv[0:0]; ci1 = ~civ;
        a13 = ~av; b13 = ~bv; ci13 = ~civ;
    endtask

    // Count edges until done (bounded) and busy-high samples along the way.
    task automatic wait_done(input int sel, output int n, output int bc);
        n  = 0;
        bc = cur_busy(sel) ? 1 : 0;
        while (!cur_done(sel) && n < 64) begin
            tick();
            n++;
            if (cur_busy(sel)) bc++;
        end
    endtask

    task automatic op(input int sel, input logic [12:0] av, input logic [12:0] bv, input logic civ,
                      input int w, input logic [31:0] exp, input string tag);
        int n;
        int bc;
        launch(sel, av, bv, civ);
        wait_done(sel, n, bc);
        chk({tag, "_lat"}, 32'(n), 32'(w));
        chk({tag, "_sum"}, cur_res(sel), exp);
        chk({tag, "_busy"}, 32'(bc), 32'(w + 1));
        tick();
        chk({tag, "_idle"}, 32'(cur_busy(sel)), 32'd0);
    endtask

    initial begin
        int          n;
        int          bc;
        int          dn;
        int          done_cyc [3];
        logic [7:0]  ha [3];
        logic [7:0]  hb [3];
        logic        hc [3];
        logic [31:0] hexp [3];
        logic [12:0] ra;
        logic [12:0] rb;
        logic        rc;

        checks = 0; errors = 0; cyc = 0;
        rst = 1'b1;
        start8 = 1'b0;  a8 = 8'h00;   b8 = 8'h00;   ci8 = 1'b0;
        start1 = 1'b0;  a1 = 1'b0;    b1 = 1'b0;    ci1 = 1'b0;
        start13 = 1'b0; a13 = 13'h0;  b13 = 13'h0;  ci13 = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_s",    32'(s8),    32'd0);
        chk("rst_co",   32'(co8),   32'd0);
        rst = 1'b0;
        tick();

        // Basic additions at WIDTH=8
        op(0, 13'h5A, 13'h3C, 1'b0, 8, 32'h096, "w8_5a_3c");
        op(0, 13'hFF, 13'h01, 1'b0, 8, 32'h100, "w8_ff_01");
        op(0, 13'hFF, 13'hFF, 1'b1, 8, 32'h1FF, "w8_ff_ff_c");

        // Start during RUN is ignored; result holds previous value meanwhile
        launch(0, 13'h05, 13'h06, 1'b0);
        tick();
        tick();
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; ci8 = 1'b0;
        tick();
        start8 = 1'b0;
        chk("ign_hold", cur_res(0), 32'h1FF);
        wait_done(0, n, bc);
        chk("ign_lat", 32'(n + 3), 32'd8);
        chk("ign_sum", cur_res(0), 32'h00B);
        tick();
        chk("ign_idle", 32'(busy8), 32'd0);
        tick();
        chk("ign_stay", 32'(busy8), 32'd0);

        // Reset at RUN cycle 4 aborts the operation
        launch(0, 13'h33, 13'h44, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_res",  cur_res(0), 32'h000);
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dn++;
        end
        chk("abort_nodone", 32'(dn), 32'd0);
        op(0, 13'h01, 13'h01, 1'b0, 8, 32'h002, "w8_after_abort");

        // Start held high: three back-to-back operations
        ha[0] = 8'h10; hb[0] = 8'h20; hc[0] = 1'b0; hexp[0] = 32'h030;
        ha[1] = 8'h7F; hb[1] = 8'h01; hc[1] = 1'b1; hexp[1] = 32'h081;
        ha[2] = 8'hC8; hb[2] = 8'h64; hc[2] = 1'b1; hexp[2] = 32'h12D;
        start8 = 1'b1; a8 = ha[0]; b8 = hb[0]; ci8 = hc[0];
        tick();
        a8 = ha[1]; b8 = hb[1]; ci8 = hc[1];
        for (int k = 0; k < 3; k++) begin
            wait_done(0, n, bc);
            done_cyc[k] = cyc;
            chk($sformatf("held_sum%0d", k), cur_res(0), hexp[k]);
            if (k > 0) chk($sformatf("held_gap%0d", k), 32'(done_cyc[k] - done_cyc[k-1]), 32'd10);
            tick();
            tick();
            if (k == 0) begin
                a8 = ha[2]; b8 = hb[2]; ci8 = hc[2];
            end
        end
        // The final two ticks above relaunched once more; drop start and drain.
        start8 = 1'b0;
        wait_done(0, n, bc);
        tick();
        tick();
        chk("held_idle", 32'(busy8), 32'd0);

        // WIDTH=1 corner cases
        op(1, 13'h1, 13'h1, 1'b1, 1, 32'h3, "w1_111");
        op(1, 13'h0, 13'h0, 1'b0, 1, 32'h0, "w1_000");
        op(1, 13'h1, 13'h0, 1'b0, 1, 32'h1, "w1_100");

        // WIDTH=13 directed full ripple
        op(2, 13'h1FFF, 13'h0001, 1'b0, 13, 32'h2000, "w13_ripple");
        op(2, 13'h1234, 13'h0ABC, 1'b1, 13, 32'h1CF1, "w13_mix");

        // Operand sweeps against a + b + ci
        for (int i = 0; i < 1000; i++) begin
            ra = 13'($urandom) & 13'h00FF;
            rb = 13'($urandom) & 13'h00FF;
            rc = 1'($urandom);
            op(0, ra, rb, rc, 8, 32'(ra) + 32'(rb) + 32'(rc), $sformatf("w8_rnd%0d", i));
        end
        for (int i = 0; i < 1000; i++) begin
            ra = 13'($urandom);
            rb = 13'($urandom);
            rc = 1'($urandom);
            op(2, ra, rb, rc, 13, 32'(ra) + 32'(rb) + 32'(rc), $sformatf("w13_rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
